div_sched: RTL

//  Sequencer and iterative datapath for DIV/MOD/DIVU/MODU in the EXE stage.

---
 rtl/div_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/div_sched.sv
// Iterative restoring divider for DIV/MOD/DIVU/MODU in the EXE stage.
// One quotient bit per cycle; quotient and remainder are returned together.
module div_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic             cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;    // divisor magnitude
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quot_res_q, quot_res_d;
    logic [WIDTH-1:0] rem_res_q, rem_res_d;

    logic [WIDTH-1:0] src1_abs, src2_abs;
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             ge;
    logic [WIDTH-1:0] rem_new, quot_new;

    // Magnitudes are taken only for signed ops; 0x80000000 maps onto itself.
    assign src1_abs = (in_signed && in_src1[WIDTH-1]) ? -in_src1 : in_src1;
    assign src2_abs = (in_signed && in_src2[WIDTH-1]) ? -in_src2 : in_src2;

    // rem_q < dvs_q, so the shifted value is below 2*dvs and the WIDTH+1 bit
    // subtraction's top bit is a clean borrow.
    assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    assign rem_sub  = rem_sh - {1'b0, dvs_q};
    assign ge       = ~rem_sub[WIDTH];
    assign rem_new  = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quot_new = {dvd_q[WIDTH-2:0], ge};

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign out_quot  = quot_res_q;
    assign out_rem   = rem_res_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            quot_res_q <= '0;
            rem_res_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            quot_res_q <= quot_res_d;
            rem_res_q  <= rem_res_d;
        end
    end

    // Next-state and datapath update; cancel overrides everything else.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        quot_res_d = quot_res_q;
        rem_res_d  = rem_res_q;

        if (cancel) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        cnt_d  = '0;
                        rem_d  = '0;
                        dvd_d  = src1_abs;
                        dvs_d  = src2_abs;
                        qneg_d = in_signed & (in_src1[WIDTH-1] ^ in_src2[WIDTH-1]);
                        rneg_d = in_signed & in_src1[WIDTH-1];
                        if (in_src2 == '0) begin
                            // Divide by zero bypasses the iteration and sign fixup.
                            quot_res_d = '1;
                            rem_res_d  = in_src1;
                            state_d    = StDone;
                        end else begin
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_d = rem_new;
                    dvd_d = quot_new;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CntLast) begin
                        quot_res_d = qneg_q ? -quot_new : quot_new;
                        rem_res_d  = rneg_q ? -rem_new : rem_new;
                        state_d    = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

endmodule
